// File: rtl/mpsoc_dbg_wb_req_sync.sv
// rtl/mpsoc_dbg_wb_req_sync.sv - debug request toggle receiver driving one Wishbone classic cycle per request
// Optional bus watchdog: define MPSOC_DBG_WB_TIMEOUT_EN.
module mpsoc_dbg_wb_req_sync #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            DEST_CLK,
    input  logic            RESET,
    input  logic            REQ_TOGGLE_I,
    input  logic [AW-1:0]   REQ_ADR_I,
    input  logic [DW-1:0]   REQ_DAT_I,
    input  logic            REQ_WE_I,
    input  logic [DW/8-1:0] REQ_SEL_I,
    output logic            ACK_TOGGLE_O,
    output logic [DW-1:0]   RSP_DAT_O,
    output logic            RSP_ERR_O,
    output logic            OVR_O,
    output logic            BUSY_O,
    output logic [AW-1:0]   WB_ADR_O,
    output logic [DW-1:0]   WB_DAT_O,
    output logic [DW/8-1:0] WB_SEL_O,
    output logic            WB_WE_O,
    output logic            WB_CYC_O,
    output logic            WB_STB_O,
    input  logic [DW-1:0]   WB_DAT_I,
    input  logic            WB_ACK_I,
    input  logic            WB_ERR_I
);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   sync1, sync2, prev;
    logic   req_evt;
    logic   bus_done;
    logic   tmo;
    logic   accept;
    logic   finish;

    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= REQ_TOGGLE_I;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign req_evt  = sync2 ^ prev;
    assign bus_done = WB_ACK_I | WB_ERR_I;

`ifdef MPSOC_DBG_WB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    // A slave answer on the expiry cycle wins over the watchdog.
    assign tmo = (state == BUS) && !bus_done && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (req_evt) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (bus_done || tmo) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            ACK_TOGGLE_O <= 1'b0;
            RSP_DAT_O    <= '0;
            RSP_ERR_O    <= 1'b0;
            OVR_O        <= 1'b0;
            BUSY_O       <= 1'b0;
            WB_ADR_O     <= '0;
            WB_DAT_O     <= '0;
            WB_SEL_O     <= '0;
            WB_WE_O      <= 1'b0;
            WB_CYC_O     <= 1'b0;
        end else begin
            if (accept) begin
                WB_ADR_O <= REQ_ADR_I;
                WB_DAT_O <= REQ_DAT_I;
                WB_SEL_O <= REQ_SEL_I;
                WB_WE_O  <= REQ_WE_I;
                WB_CYC_O <= 1'b1;
                BUSY_O   <= 1'b1;
            end
            if (finish) begin
                WB_CYC_O     <= 1'b0;
                BUSY_O       <= 1'b0;
                ACK_TOGGLE_O <= ~ACK_TOGGLE_O;
                if (bus_done) begin
                    if (!WB_WE_O) begin
                        RSP_DAT_O <= WB_DAT_I;
                    end
                    RSP_ERR_O <= WB_ERR_I & ~WB_ACK_I;
                end else begin
                    RSP_DAT_O <= '0;
                    RSP_ERR_O <= 1'b1;
                end
            end
            // Requests arriving mid-cycle are dropped, only flagged.
            if (req_evt && (state == BUS)) begin
                OVR_O <= 1'b1;
            end
        end
    end

    assign WB_STB_O = WB_CYC_O;

endmodule
